// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator for the median filter path.
// Two line buffers feed a 3x3 shift register; win_valid flags complete, non-wrapping windows.
module window_gen_3x3 #(
  parameter int WIDTH    = 9,
  parameter int LINE_LEN = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_pixel,
  output logic             win_valid,
  output logic [WIDTH-1:0] x_0,
  output logic [WIDTH-1:0] x_1,
  output logic [WIDTH-1:0] x_2,
  output logic [WIDTH-1:0] x_3,
  output logic [WIDTH-1:0] x_4,
  output logic [WIDTH-1:0] x_5,
  output logic [WIDTH-1:0] x_6,
  output logic [WIDTH-1:0] x_7,
  output logic [WIDTH-1:0] x_8
);
  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_eff;
  logic [1:0]       row;
  logic [1:0]       row_eff;
  logic [WIDTH-1:0] lb1 [LINE_LEN];
  logic [WIDTH-1:0] lb2 [LINE_LEN];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] win [9];

  // Start of frame overrides whatever position the counters held.
  always_comb begin
    col_eff = in_sof ? '0 : col;
    row_eff = in_sof ? '0 : row;
  end

  assign rd_a = lb2[col_eff];
  assign rd_b = lb1[col_eff];

  // Line buffers carry no reset; stale contents are masked by the row qualifier.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb2[col_eff] <= rd_b;
      lb1[col_eff] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      win_valid <= 1'b0;
      if (in_valid) begin
        win[0] <= win[1];
        win[3] <= win[4];
        win[6] <= win[7];
        win[1] <= win[2];
        win[4] <= win[5];
        win[7] <= win[8];
        win[2] <= rd_a;
        win[5] <= rd_b;
        win[8] <= in_pixel;
        win_valid <= (row_eff == 2'd2) && (col_eff >= COL_FIRST_WIN);
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
        end else begin
          col <= col_eff + COL_W'(1);
          row <= row_eff;
        end
      end
    end
  end

  assign x_0 = win[0];
  assign x_1 = win[1];
  assign x_2 = win[2];
  assign x_3 = win[3];
  assign x_4 = win[4];
  assign x_5 = win[5];
  assign x_6 = win[6];
  assign x_7 = win[7];
  assign x_8 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 with LINE_LEN=4; a frame-image model feeds
// a window scoreboard that a negedge monitor drains on every strobe.
module tb_window_gen_3x3;
  localparam int W = 9;
  localparam int LL = 4;

  typedef logic [9*W-1:0] win_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [W-1:0] in_pixel = '0;
  logic         win_valid;
  logic [W-1:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobe_cnt = 0;
  logic acc_prev = 1'b0;

  win_t exp_q[$];
  logic [W-1:0] img [16][LL];
  int mrow = 0;
  int mcol = 0;

  window_gen_3x3 #(.WIDTH(W), .LINE_LEN(LL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(win_valid),
    .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4),
    .x_5(x_5), .x_6(x_6), .x_7(x_7), .x_8(x_8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) acc_prev <= in_valid && !rst;

  // Scoreboard monitor: every strobe must follow an accepted pixel and match the model.
  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      win_t got;
      win_t e;
      got = {x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};
      strobe_cnt++;
      total_cnt++;
      if (!acc_prev) begin
        $display("FAIL strobe_without_pixel: win_valid=1 required no strobe");
      end else if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got window %h, required none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) $display("FAIL window_taps: got %h required %h", got, e);
        else pass_cnt++;
      end
    end
  end

  function automatic logic [W-1:0] pix(input int mode, input int base, input int r, input int c);
    case (mode)
      0:       return W'(base + 16 * r + c);
      1:       return 9'h1FF;
      default: return ((r + c) % 2 == 1) ? 9'h1FF : 9'h000;
    endcase
  endfunction

  task automatic model_reset();
    mrow = 0;
    mcol = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [W-1:0] p, input logic sof, output logic strobe);
    win_t w;
    if (sof) begin
      mrow = 0;
      mcol = 0;
    end
    img[mrow][mcol] = p;
    strobe = (mrow >= 2) && (mcol >= 2);
    if (strobe) begin
      w = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[(i*3+j)*W +: W] = img[mrow-2+i][mcol-2+j];
      exp_q.push_back(w);
    end
    if (mcol == LL - 1) begin
      mcol = 0;
      if (mrow < 15) mrow++;
    end else begin
      mcol++;
    end
  endtask

  // Presents one pixel for exactly one edge; returns at #1 after that edge.
  task automatic drive_px(input logic [W-1:0] p, input logic sof, output logic strobe);
    model_accept(p, sof, strobe);
    in_pixel = p;
    in_sof   = sof;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_frame(input int rows, input int mode, input int base, input int max_gap,
                           input bit first_sof);
    logic es;
    int gap;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < LL; c++) begin
        drive_px(pix(mode, base, r, c), first_sof && r == 0 && c == 0, es);
        total_cnt++;
        if (win_valid !== es)
          $display("FAIL strobe_timing r%0d c%0d: win_valid=%b required %b", r, c, win_valid, es);
        else pass_cnt++;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_pixel = 9'h155;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    total_cnt++;
    if (win_valid !== 1'b0) $display("FAIL reset_win_valid: got %b required 0", win_valid);
    else pass_cnt++;
    total_cnt++;
    if ({x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0} !== '0)
      $display("FAIL reset_taps: got %h required 0", {x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0});
    else pass_cnt++;
  endtask

  task automatic check_frame_end(input string name, input int s0);
    total_cnt++;
    if (strobe_cnt - s0 !== 4) $display("FAIL %s_strobe_count: got %0d required 4", name, strobe_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL %s_pending: got %0d windows left required 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_continuous();
    int s0 = strobe_cnt;
    run_frame(4, 0, 0, 0, 1);
    check_frame_end("continuous", s0);
    total_cnt++;
    if (x_8 !== 9'h033) $display("FAIL last_x8: got %h required 033", x_8);
    else pass_cnt++;
    total_cnt++;
    if (x_0 !== 9'h011) $display("FAIL last_x0: got %h required 011", x_0);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    int s0 = strobe_cnt;
    run_frame(4, 0, 0, 3, 1);
    check_frame_end("gaps", s0);
  endtask

  task automatic test_line_boundary();
    logic es;
    int s0 = strobe_cnt;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LL; c++) begin
        drive_px(pix(0, 0, r, c), r == 0 && c == 0, es);
        if (r == 3 && c < 2) begin
          total_cnt++;
          if (win_valid !== 1'b0) $display("FAIL boundary_no_strobe c%0d: got %b required 0", c, win_valid);
          else pass_cnt++;
        end
        if (r == 3 && c == 1) begin
          total_cnt++;
          if (x_8 !== 9'h031) $display("FAIL boundary_x8: got %h required 031", x_8);
          else pass_cnt++;
          total_cnt++;
          if (x_7 !== 9'h030) $display("FAIL boundary_x7: got %h required 030", x_7);
          else pass_cnt++;
        end
      end
    end
    @(negedge clk);
    #1;
    check_frame_end("boundary", s0);
  endtask

  task automatic test_mid_sof();
    logic es;
    int s0 = strobe_cnt;
    for (int k = 0; k < 10; k++) begin
      drive_px(pix(0, 0, k / LL, k % LL), k == 0, es);
      total_cnt++;
      if (win_valid !== 1'b0) $display("FAIL partial_frame_strobe k%0d: got %b required 0", k, win_valid);
      else pass_cnt++;
    end
    run_frame(4, 0, 9'h100, 0, 1);
    check_frame_end("mid_sof", s0);
  endtask

  task automatic test_reset_restart();
    logic es;
    int s0;
    for (int k = 0; k < 11; k++) drive_px(pix(0, 0, k / LL, k % LL), k == 0, es);
    total_cnt++;
    if (win_valid !== 1'b1 || x_8 !== 9'h022)
      $display("FAIL pre_reset_window: win_valid=%b x_8=%h required 1/022", win_valid, x_8);
    else pass_cnt++;
    rst = 1'b1;
    in_valid = 1'b1;
    in_pixel = 9'h0AA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    total_cnt++;
    if ({win_valid, x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0} !== '0)
      $display("FAIL midframe_reset_outputs: got %h required 0",
               {win_valid, x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0});
    else pass_cnt++;
    s0 = strobe_cnt;
    run_frame(4, 0, 0, 0, 0);
    check_frame_end("restart", s0);
  endtask

  task automatic test_full_scale();
    int s0 = strobe_cnt;
    run_frame(4, 1, 0, 0, 1);
    check_frame_end("all_ones", s0);
    s0 = strobe_cnt;
    run_frame(4, 2, 0, 1, 1);
    check_frame_end("checker", s0);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_line_boundary();
    test_mid_sof();
    test_reset_restart();
    test_full_scale();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
